alu_instr_sequencer: RTL
========================

Name: alu_instr_sequencer

Overview:
- Hardware control sequencer for register–register ALU instructions; replaces the hand-stepped T0–T5 signal pattern with an FSM.
- Sits beside the datapath. It drives all datapath enables, BusDataSelect, GP_addr and ALU_op.
- Runs fetch (T0–T2) and execute (T3–T5/T6), with a memory-ready handshake, configurable step length, two-result ops (HI/LO) and illegal-instruction detection.

Parameters:
- NUM_GP, 16, number of implemented GP registers; register index >= NUM_GP is illegal.
- GP_AW, 4, GP_addr width.
- ALU_OPW, 4, ALU_op width.
- STEP_CYCLES, 1, clocks each T-state holds its enables (1..15).
- SEL_ZHI, 5'h12, BusDataSelect code for Z high.
- SEL_ZLO, 5'h13, BusDataSelect code for Z low.
- SEL_PC, 5'h14, BusDataSelect code for PC.
- SEL_MDR, 5'h15, BusDataSelect code for MDR.

Ports:
- clock, in, 1, system clock; all state changes on rising edge.
- clear, in, 1, asynchronous active-high reset.
- start, in, 1, begin one instruction; sampled only in IDLE.
- mem_ready, in, 1, memory data valid on Mdatain during T1.
- ir, in, 32, IR contents (datapath IR output); decoded in T3.
- BusDataSelect, out, 5, bus source select; GP register n = {1'b0, n}.
- GP_addr, out, GP_AW, GP write/read index.
- e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP, out, 1 each, register load enables.
- incPC, out, 1, ALU PC+1 mode for T0.
- MDR_read, out, 1, MDR takes Mdatain.
- ALU_op, out, ALU_OPW, ALU operation.
- busy, out, 1, high in any state other than IDLE.
- done, out, 1, one-cycle pulse when the final write step completes.
- illegal, out, 1, one-cycle pulse on a decode failure.

Behaviour:
- Reset (async on clear=1): state IDLE, step counter 0, all enables/incPC/MDR_read/done/illegal 0, BusDataSelect 0, GP_addr 0, ALU_op 0.
- Reset mid-instruction aborts immediately; no partial write follows.
- Outputs are registered and decoded from state, so each T-state's signals are valid for exactly STEP_CYCLES clocks.
- IR fields: opcode = ir[31:27], Ra = ir[26:23] (dest), Rb = ir[22:19], Rc = ir[18:15].
- Opcode decode:
  - 5'd3..5'd12: single-result; ALU_op = ir[30:27] zero-extended or truncated to ALU_OPW.
  - 5'd15 (MUL) and 5'd16 (DIV): two-result; ALU_op = 4'hE and 4'hF respectively.
  - All other opcodes: illegal.
- IDLE: all enables 0. On start=1, go to T0 on the next edge. start while busy is ignored.
- T0: BusDataSelect=SEL_PC, e_MAR=1, incPC=1, e_Z=1.
- T1: BusDataSelect=SEL_ZLO, e_PC=1, MDR_read=1, e_MDR=1.
  - Stays in T1 while mem_ready=0; e_PC pulses only in the first T1 cycle.
  - Advance requires mem_ready=1 and at least STEP_CYCLES elapsed.
- T2: BusDataSelect=SEL_MDR, e_IR=1.
- T3: decode ir.
  - Illegal opcode, or any used index >= NUM_GP: pulse illegal, all enables 0, go to IDLE. No Y/Z/GP write occurs.
  - Otherwise BusDataSelect={1'b0, Rb}, e_Y=1.
- T4: BusDataSelect={1'b0, Rc}, ALU_op per decode, e_Z=1.
- T5:
  - Single-result: BusDataSelect=SEL_ZLO, GP_addr=Ra, e_GP=1; then done pulses and the FSM returns to IDLE.
  - Two-result: BusDataSelect=SEL_ZLO, e_LO=1; go to T6.
- T6 (two-result only): BusDataSelect=SEL_ZHI, e_HI=1; then done, IDLE.
- At most one e_* write enable is high in any cycle, except T0 (e_MAR and e_Z together) and T1 (e_PC and e_MDR together).
- done and illegal are never high in the same cycle.
- A start arriving in the same cycle as done is ignored. The next start is accepted from IDLE, one cycle later.
- Latency from start to done, with mem_ready already high: 6×STEP_CYCLES+1 clocks single-result, 7×STEP_CYCLES+1 clocks two-result.

Test Plan:
- Reset mid-T4 (clear pulse): all outputs 0 asynchronously, busy=0; the following start runs a clean T0.
- ROL, STEP_CYCLES=1, mem_ready=1, ir=32'h2A338000 (opcode 5, Ra=4, Rb=6, Rc=7):
  - T3 BusDataSelect=5'h06 with e_Y.
  - T4 BusDataSelect=5'h07 with ALU_op=4'h5.
  - T5 GP_addr=4 with e_GP.
  - done 7 clocks after start.
- mem_ready held 0 for 3 cycles in T1: MDR_read stays high 4 cycles, e_PC high 1 cycle only, T2 follows mem_ready.
- MUL, ir opcode 5'd15: T5 has e_LO with SEL_ZLO, T6 has e_HI with SEL_ZHI, e_GP never asserted, done at 8 clocks.
- Illegal opcode 5'd31, or NUM_GP=8 with Rc=9: illegal pulses in T3; e_Y, e_Z, e_GP, e_HI, e_LO stay 0; busy drops next cycle.
- STEP_CYCLES=3: each T-state holds 3 clocks; start held continuously during the run is not re-accepted until the cycle after done.

Source files
------------

// File: rtl/alu_instr_sequencer.sv
// Control sequencer for register-register ALU instructions: walks fetch (T0-T2) and
// execute (T3-T5/T6) and drives every datapath enable from registered, state-decoded outputs.
module alu_instr_sequencer #(
  parameter int             NUM_GP      = 16,
  parameter int             GP_AW       = 4,
  parameter int             ALU_OPW     = 4,
  parameter int             STEP_CYCLES = 1,
  parameter logic [4:0]     SEL_ZHI     = 5'h12,
  parameter logic [4:0]     SEL_ZLO     = 5'h13,
  parameter logic [4:0]     SEL_PC      = 5'h14,
  parameter logic [4:0]     SEL_MDR     = 5'h15
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic               mem_ready,
  input  logic [31:0]        ir,
  output logic [4:0]         BusDataSelect,
  output logic [GP_AW-1:0]   GP_addr,
  output logic               e_PC,
  output logic               e_IR,
  output logic               e_Y,
  output logic               e_Z,
  output logic               e_HI,
  output logic               e_LO,
  output logic               e_MDR,
  output logic               e_MAR,
  output logic               e_GP,
  output logic               incPC,
  output logic               MDR_read,
  output logic [ALU_OPW-1:0] ALU_op,
  output logic               busy,
  output logic               done,
  output logic               illegal
);

  typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6} state_t;

  typedef struct packed {
    logic [4:0]         bds;
    logic [GP_AW-1:0]   gp_addr;
    logic [ALU_OPW-1:0] alu_op;
    logic e_pc, e_ir, e_y, e_z, e_hi, e_lo, e_mdr, e_mar, e_gp;
    logic inc_pc, mdr_read, busy, done, illegal;
  } ctl_t;

  state_t             r_state, w_next;
  logic [3:0]         r_step;
  ctl_t               r_ctl, w_ctl;
  logic [3:0]         r_ra, r_rb, r_rc;
  logic [ALU_OPW-1:0] r_op;
  logic               r_two;

  logic               w_step_end, w_single, w_two, w_idx_bad, w_illegal, w_enter_t3;
  logic [4:0]         w_opc;
  logic [3:0]         w_rb;
  logic [ALU_OPW-1:0] w_alu_op;
  logic               w_unused;

  assign w_unused   = ^ir[14:0];
  assign w_step_end = (r_step == 4'(STEP_CYCLES - 1));

  // Decode is sampled on the edge that enters T3, then held in r_* for T4..T6.
  assign w_opc      = ir[31:27];
  assign w_single   = (w_opc >= 5'd3) && (w_opc <= 5'd12);
  assign w_two      = (w_opc == 5'd15) || (w_opc == 5'd16);
  assign w_idx_bad  = ({28'd0, ir[26:23]} >= 32'(NUM_GP)) ||
                      ({28'd0, ir[22:19]} >= 32'(NUM_GP)) ||
                      ({28'd0, ir[18:15]} >= 32'(NUM_GP));
  assign w_illegal  = !(w_single || w_two) || w_idx_bad;
  assign w_alu_op   = w_two ? ((w_opc == 5'd15) ? ALU_OPW'(4'hE) : ALU_OPW'(4'hF))
                            : ALU_OPW'(ir[30:27]);
  assign w_enter_t3 = (r_state == S_T2) && (w_next == S_T3);
  assign w_rb       = (r_state == S_T2) ? ir[22:19] : r_rb;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start && !r_ctl.done) w_next = S_T0;
      S_T0:    if (w_step_end) w_next = S_T1;
      S_T1:    if (w_step_end && mem_ready) w_next = S_T2;
      S_T2:    if (w_step_end) w_next = S_T3;
      S_T3:    if (r_ctl.illegal) w_next = S_IDLE;
               else if (w_step_end) w_next = S_T4;
      S_T4:    if (w_step_end) w_next = S_T5;
      S_T5:    if (w_step_end) w_next = r_two ? S_T6 : S_IDLE;
      S_T6:    if (w_step_end) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are computed for the state being entered so they line up with r_state.
  always_comb begin
    w_ctl      = '0;
    w_ctl.busy = (w_next != S_IDLE);
    case (w_next)
      S_T0: begin
        w_ctl.bds = SEL_PC; w_ctl.e_mar = 1'b1; w_ctl.inc_pc = 1'b1; w_ctl.e_z = 1'b1;
      end
      S_T1: begin
        w_ctl.bds      = SEL_ZLO;
        w_ctl.e_pc     = (r_state != S_T1);
        w_ctl.mdr_read = 1'b1;
        w_ctl.e_mdr    = 1'b1;
      end
      S_T2: begin
        w_ctl.bds = SEL_MDR; w_ctl.e_ir = 1'b1;
      end
      S_T3: begin
        if ((r_state == S_T2) && w_illegal) begin
          w_ctl.illegal = 1'b1;
        end else begin
          w_ctl.bds = {1'b0, w_rb}; w_ctl.e_y = 1'b1;
        end
      end
      S_T4: begin
        w_ctl.bds = {1'b0, r_rc}; w_ctl.alu_op = r_op; w_ctl.e_z = 1'b1;
      end
      S_T5: begin
        w_ctl.bds = SEL_ZLO;
        if (r_two) begin
          w_ctl.e_lo = 1'b1;
        end else begin
          w_ctl.gp_addr = GP_AW'(r_ra); w_ctl.e_gp = 1'b1;
        end
      end
      S_T6: begin
        w_ctl.bds = SEL_ZHI; w_ctl.e_hi = 1'b1;
      end
      default: begin
        w_ctl.done = (r_state == S_T5) || (r_state == S_T6);
      end
    endcase
  end

  // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= S_IDLE;
      r_step  <= '0;
      r_ctl   <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_rc    <= '0;
      r_op    <= '0;
      r_two   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ctl   <= w_ctl;
      if (w_next != r_state) r_step <= '0;
      else if (!w_step_end)  r_step <= r_step + 4'd1;
      if (w_enter_t3) begin
        r_ra  <= ir[26:23];
        r_rb  <= ir[22:19];
        r_rc  <= ir[18:15];
        r_op  <= w_alu_op;
        r_two <= w_two;
      end
    end
  end

  assign BusDataSelect = r_ctl.bds;
  assign GP_addr       = r_ctl.gp_addr;
  assign ALU_op        = r_ctl.alu_op;
  assign e_PC          = r_ctl.e_pc;
  assign e_IR          = r_ctl.e_ir;
  assign e_Y           = r_ctl.e_y;
  assign e_Z           = r_ctl.e_z;
  assign e_HI          = r_ctl.e_hi;
  assign e_LO          = r_ctl.e_lo;
  assign e_MDR         = r_ctl.e_mdr;
  assign e_MAR         = r_ctl.e_mar;
  assign e_GP          = r_ctl.e_gp;
  assign incPC         = r_ctl.inc_pc;
  assign MDR_read      = r_ctl.mdr_read;
  assign busy          = r_ctl.busy;
  assign done          = r_ctl.done;
  assign illegal       = r_ctl.illegal;

endmodule
